// File: rtl/llc_rst_flush_sweep_if.sv
// Request/completion handshake between a reset/flush requester and the LLC set-walking sequencer.
interface llc_rst_flush_sweep_if;
  logic req_valid;
  logic req_is_flush;
  logic req_ready;
  logic done_valid;
  logic done_is_flush;
  logic done_ready;

  modport master (
    output req_valid, req_is_flush, done_ready,
    input  req_ready, done_valid, done_is_flush
  );

  modport slave (
    input  req_valid, req_is_flush, done_ready,
    output req_ready, done_valid, done_is_flush
  );
endinterface

// File: rtl/llc_rst_flush_sweep.sv
// Walks a set index across every LLC set for one reset or flush request at a time,
// advancing when the update stage reports the current set written, then returns a completion.
module llc_rst_flush_sweep #(
  parameter int LLC_SETS = 256,
  parameter int SET_BITS = $clog2(LLC_SETS)
) (
  input  logic                 clk,
  input  logic                 rst,
  llc_rst_flush_sweep_if.slave host,
  input  logic                 incr_rst_flush_stalled_set,
  output logic [SET_BITS-1:0]  stalled_set,
  output logic                 is_rst_to_resume,
  output logic                 is_flush_to_resume,
  output logic                 sweep_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(LLC_SETS - 1);

  state_t              state;
  state_t              state_nxt;
  logic                kind;
  logic [SET_BITS-1:0] set_idx;
  logic                accept;
  logic                advance;
  logic                last_step;

  assign accept    = host.req_valid && (state == IDLE);
  assign advance   = (state == SWEEP) && incr_rst_flush_stalled_set;
  assign last_step = advance && (set_idx == LAST_SET);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)                         state_nxt = SWEEP;
      SWEEP:   if (last_step)                      state_nxt = DONE;
      DONE:    if (host.done_ready)                state_nxt = IDLE;
      default:                                     state_nxt = IDLE;
    endcase
  end

  // The index only wraps on the completion step, so it never runs past the last set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_idx <= '0;
      kind    <= 1'b0;
    end else begin
      if (accept) begin
        set_idx <= '0;
        kind    <= host.req_is_flush;
      end else if (last_step) begin
        set_idx <= '0;
      end else if (advance) begin
        set_idx <= set_idx + SET_BITS'(1);
      end
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    host.req_ready     = 1'b0;
    host.done_valid    = 1'b0;
    host.done_is_flush = 1'b0;
    is_rst_to_resume   = 1'b0;
    is_flush_to_resume = 1'b0;
    sweep_active       = 1'b0;
    case (state)
      IDLE:  host.req_ready = 1'b1;
      SWEEP: begin
        sweep_active       = 1'b1;
        is_rst_to_resume   = !kind;
        is_flush_to_resume = kind;
      end
      DONE: begin
        host.done_valid    = 1'b1;
        host.done_is_flush = kind;
      end
      default: ;
    endcase
  end

  assign stalled_set = set_idx;

endmodule

// File: tb/tb_llc_rst_flush_sweep.sv
// Self-checking bench: directed scenarios plus randomized traffic against a set-counting reference model.
module tb_llc_rst_flush_sweep;

  localparam int SETS = 4;
  localparam int SB   = $clog2(SETS);

  logic          clk = 1'b0;
  logic          rst;
  logic          incr;
  logic [SB-1:0] stalled_set;
  logic          is_rst_to_resume;
  logic          is_flush_to_resume;
  logic          sweep_active;

  llc_rst_flush_sweep_if bus ();

  llc_rst_flush_sweep #(.LLC_SETS(SETS)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .host                       (bus.slave),
    .incr_rst_flush_stalled_set (incr),
    .stalled_set                (stalled_set),
    .is_rst_to_resume           (is_rst_to_resume),
    .is_flush_to_resume         (is_flush_to_resume),
    .sweep_active               (sweep_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a walk in progress, a pending completion, the walk position and its kind.
  bit m_walking;
  bit m_done_pending;
  int m_pos;
  bit m_flush;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    m_walking      = 0;
    m_done_pending = 0;
    m_pos          = 0;
    m_flush        = 0;
  endtask

  task automatic model_step();
    if (m_done_pending) begin
      if (bus.done_ready) m_done_pending = 0;
    end else if (m_walking) begin
      if (incr) begin
        if (m_pos == SETS - 1) begin
          m_walking      = 0;
          m_done_pending = 1;
          m_pos          = 0;
        end else begin
          m_pos = m_pos + 1;
        end
      end
    end else if (bus.req_valid) begin
      m_walking = 1;
      m_flush   = bus.req_is_flush;
      m_pos     = 0;
    end
  endtask

  task automatic check_outputs();
    check("req_ready",     32'(bus.req_ready),     32'(!m_walking && !m_done_pending));
    check("stalled_set",   32'(stalled_set),       32'(m_pos));
    check("is_rst",        32'(is_rst_to_resume),  32'(m_walking && !m_flush));
    check("is_flush",      32'(is_flush_to_resume),32'(m_walking && m_flush));
    check("sweep_active",  32'(sweep_active),      32'(m_walking));
    check("done_valid",    32'(bus.done_valid),    32'(m_done_pending));
    check("done_is_flush", 32'(bus.done_is_flush), 32'(m_done_pending && m_flush));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    bus.req_valid    = 1'b0;
    bus.req_is_flush = 1'b0;
    bus.done_ready   = 1'b0;
    incr             = 1'b0;
  endtask

  task automatic start_sweep(input bit flush);
    bus.req_valid    = 1'b1;
    bus.req_is_flush = flush;
    tick();
    bus.req_valid    = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_done_valid", 32'(bus.done_valid), 32'd0);
    check("rst_set",        32'(stalled_set),    32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_outputs();

    // Reset sweep, back-to-back pulses
    bus.req_valid = 1'b1;
    check("accept_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    check("rst_flag_on", 32'(is_rst_to_resume), 32'd1);
    incr = 1'b1;
    for (int i = 0; i < SETS; i++) begin
      check("walk_set", 32'(stalled_set), 32'(i));
      tick();
    end
    incr = 1'b0;
    check("done_after_walk", 32'(bus.done_valid),       32'd1);
    check("done_kind_rst",   32'(bus.done_is_flush),    32'd0);
    check("rst_flag_off",    32'(is_rst_to_resume),     32'd0);
    check("set_wrapped",     32'(stalled_set),          32'd0);
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;

    // Flush sweep with incr every third cycle
    start_sweep(1'b1);
    for (int c = 0; c < 3 * SETS; c++) begin
      incr = (c % 3 == 2);
      tick();
    end
    incr = 1'b0;
    check("flush_done_kind", 32'(bus.done_is_flush), 32'd1);

    // Completion backpressure
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_done_held", 32'(bus.done_valid), 32'd1);
      check("bp_not_ready", 32'(bus.req_ready),  32'd0);
    end
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    check("bp_back_idle", 32'(bus.req_ready), 32'd1);

    // Flush request held while a reset sweep runs
    start_sweep(1'b0);
    bus.req_valid    = 1'b1;
    bus.req_is_flush = 1'b1;
    bus.done_ready   = 1'b1;
    for (int c = 0; c < 40; c++) begin
      incr = 1'($urandom_range(0, 1));
      if (m_walking && m_flush) bus.req_valid = 1'b0;
      tick();
    end
    idle_inputs();
    check("held_req_served", 32'(m_walking || m_done_pending), 32'd0);

    // Spurious incr in IDLE and in DONE
    incr = 1'b1;
    repeat (3) tick();
    check("idle_incr_set", 32'(stalled_set), 32'd0);
    incr = 1'b0;
    start_sweep(1'b0);
    incr = 1'b1;
    repeat (SETS + 3) tick();
    incr = 1'b0;
    check("done_incr_hold", 32'(bus.done_valid), 32'd1);
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;

    // Asynchronous reset mid-sweep at set 2
    start_sweep(1'b1);
    incr = 1'b1;
    for (int c = 0; c < 10 && m_pos != 2; c++) tick();
    incr = 1'b0;
    check("pre_abort_set", 32'(stalled_set), 32'd2);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("abort_set",      32'(stalled_set),        32'd0);
    check("abort_flush",    32'(is_flush_to_resume), 32'd0);
    check("abort_active",   32'(sweep_active),       32'd0);
    check("abort_done",     32'(bus.done_valid),     32'd0);
    check("abort_ready",    32'(bus.req_ready),      32'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.done_ready = 1'b1;
    repeat (8) tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid    = ($urandom_range(0, 3) == 0);
      bus.req_is_flush = 1'($urandom_range(0, 1));
      bus.done_ready   = ($urandom_range(0, 2) != 0);
      incr             = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
